seg7_scan_ctrl: RTL and testbench
=================================

SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 The block SHALL have parameter REFRESH_DIV, default 50000: clock cycles each digit is shown; legal values are 2 or more.
REQ-002 The block SHALL have parameter STABLE_CYCLES, default 16: consecutive cycles an input must hold before it is committed; legal values are 1 or more.
REQ-003 The block SHALL have port clk_pi, input, 1 bit: the single clock, rising edge.
REQ-004 The block SHALL have port rst_pi, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port value_pi, input, 4 bits: binary value from the Gray converter, range 0-15.
REQ-006 The block SHALL have port value_po, output, 4 bits: the committed (filtered) value.
REQ-007 The block SHALL have port update_po, output, 1 bit: one-cycle pulse when value_po is committed.
REQ-008 The block SHALL have port anodo_po, output, 2 bits: digit enables, active-low; bit0 = units, bit1 = tens.
REQ-009 The block SHALL have port catodo_po, output, 7 bits: segments, active-low; bit0 = a through bit6 = g.

Function
REQ-010 The stability filter SHALL hold a candidate register and a counter of width $clog2(STABLE_CYCLES)+1.
REQ-011 When value_pi differs from the candidate on an edge, the filter SHALL load value_pi into the candidate and clear the counter.
REQ-012 When value_pi equals the candidate, the filter SHALL increment the counter and saturate it at STABLE_CYCLES-1.
REQ-013 If value_pi changes before edge k and then holds, commit SHALL occur at edge k+STABLE_CYCLES: value_po updates and update_po=1 for that single cycle.
REQ-014 After the first commit, re-committing an unchanged value SHALL NOT pulse update_po, and value_po SHALL NOT change.
REQ-015 A glitch shorter than STABLE_CYCLES SHALL NOT alter value_po.
REQ-016 The digit split SHALL be units = value_po mod 10 and tens = value_po / 10 (0 or 1), computed combinationally from value_po.
REQ-017 The FSM SHALL have states BLANK, SHOW_UNITS and SHOW_TENS.
REQ-018 In BLANK, outputs SHALL be anodo_po=2'b11 and catodo_po=7'h7F; on the first commit the FSM SHALL go to SHOW_UNITS with the refresh counter set to 0.
REQ-019 In SHOW_UNITS, outputs SHALL be anodo_po=2'b10 and catodo_po=pattern(units).
REQ-020 In SHOW_TENS, outputs SHALL be anodo_po=2'b01 and catodo_po=pattern(tens).
REQ-021 The refresh counter SHALL count 0..REFRESH_DIV-1; at REFRESH_DIV-1 it SHALL wrap to 0 and the FSM SHALL toggle SHOW_UNITS<->SHOW_TENS on the same edge.
REQ-022 The FSM SHALL return to BLANK only on reset.
REQ-023 When a commit and a refresh wrap occur on the same edge, both SHALL take effect, and the new digits SHALL appear from the following cycle.
REQ-024 anodo_po and catodo_po SHALL be registered outputs, with no combinational path from value_pi.
REQ-025 The segment patterns SHALL be: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10.

Reset
REQ-026 While rst_pi=0 at an edge, the block SHALL set anodo_po=2'b11, catodo_po=7'h7F, value_po=0, update_po=0, candidate=0, all counters=0 and state BLANK.
REQ-027 Reset SHALL override every other event, including during a scan or mid-filter, and SHALL discard any pending commit.
REQ-028 After release, the first commit SHALL require a full STABLE_CYCLES of stable input, including for value 0.

Configuration
REQ-029 With SEG7_LEADING_ZERO_BLANK_EN defined, SHOW_TENS SHALL drive catodo_po=7'h7F when tens=0; anodo_po is unchanged and scan timing is unchanged.
REQ-030 Without SEG7_LEADING_ZERO_BLANK_EN, SHOW_TENS SHALL show pattern(0)=7'h40 when tens=0.

Structure
REQ-031 Package seg7_pkg SHALL hold the FSM state enum, the ten segment-pattern constants, SEG_BLANK=7'h7F, ANODE_OFF=2'b11, and the typedefs seg_t (7 bits) and digit_t (4 bits).
REQ-032 The block SHALL instantiate one sub-module, seg7_digit_decode (digit_t to seg_t, combinational, 7'h7F for inputs above 9), twice: once for units, once for tens.

Verification (REFRESH_DIV=4, STABLE_CYCLES=3 for sim)
REQ-033 Reset, then value_pi=0 held -> display dark until commit, then value_po=0, one update_po pulse, and anodo_po cycles 10 (4 cycles) then 01 (4 cycles).
REQ-034 value_pi=13 held -> commit exactly 3 edges after the change; units slot shows catodo_po=7'h30, tens slot shows 7'h79.
REQ-035 Committed value 5, then value_pi=9 for 2 cycles and back to 5 -> value_po stays 5 and update_po stays 0.
REQ-036 Committed value 7, with and without SEG7_LEADING_ZERO_BLANK_EN -> tens slot shows 7'h7F and 7'h40 respectively.
REQ-037 rst_pi=0 for one cycle mid-SHOW_TENS -> next cycle anodo_po=11, catodo_po=7'h7F, value_po=0; recovery follows REQ-033.
REQ-038 A commit aligned with a refresh wrap (value 15 replacing 10) -> the slot toggles on that edge, and units shows 7'h12 from the following cycle.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types and constants for the seg7 scan controller.
// Segment patterns are active-low, bit0 = a through bit6 = g.
package seg7_pkg;

  typedef logic [6:0] seg_t;
  typedef logic [3:0] digit_t;

  typedef enum logic [1:0] {
    BLANK      = 2'd0,
    SHOW_UNITS = 2'd1,
    SHOW_TENS  = 2'd2
  } state_e;

  localparam seg_t SEG_0 = 7'h40;
  localparam seg_t SEG_1 = 7'h79;
  localparam seg_t SEG_2 = 7'h24;
  localparam seg_t SEG_3 = 7'h30;
  localparam seg_t SEG_4 = 7'h19;
  localparam seg_t SEG_5 = 7'h12;
  localparam seg_t SEG_6 = 7'h02;
  localparam seg_t SEG_7 = 7'h78;
  localparam seg_t SEG_8 = 7'h00;
  localparam seg_t SEG_9 = 7'h10;

  localparam seg_t SEG_BLANK = 7'h7F;

  localparam logic [1:0] ANODE_OFF   = 2'b11;
  localparam logic [1:0] ANODE_UNITS = 2'b10;
  localparam logic [1:0] ANODE_TENS  = 2'b01;

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Bundle of the value/display signals around seg7_scan_ctrl.
// master drives the raw value, slave is the controller side.
interface seg7_scan_ctrl_if;

  logic [3:0] value;
  logic [3:0] committed;
  logic       update;
  logic [1:0] anode;
  logic [6:0] segs;

  modport master (
    output value,
    input  committed,
    input  update,
    input  anode,
    input  segs
  );

  modport slave (
    input  value,
    output committed,
    output update,
    output anode,
    output segs
  );

endinterface

// File: rtl/seg7_digit_decode.sv
// Combinational digit to active-low segment decoder.
// Inputs above 9 produce a dark digit.
module seg7_digit_decode
  import seg7_pkg::*;
(
  input  digit_t digit_i,
  output seg_t   seg_o
);

  // Map one BCD digit to its segment pattern
  always_comb begin
    seg_o = SEG_BLANK;
    case (digit_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Stability filter plus two-digit multiplexed 7-segment scanner.
// Define SEG7_LEADING_ZERO_BLANK_EN to darken a zero tens digit.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV   = 50000,
  parameter int STABLE_CYCLES = 16
) (
  input  logic       clk_pi,
  input  logic       rst_pi,
  input  logic [3:0] value_pi,
  output logic [3:0] value_po,
  output logic       update_po,
  output logic [1:0] anodo_po,
  output logic [6:0] catodo_po
);

  localparam int CW = $clog2(STABLE_CYCLES) + 1;
  localparam int RW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);
  localparam logic [RW-1:0] REF_MAX = RW'(REFRESH_DIV - 1);

  logic [3:0]    cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    val_q, val_d;
  logic          upd_q, upd_d;
  logic          done_q, done_d;
  state_e        state_q, state_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic [1:0]    an_q, an_d;
  seg_t          seg_q, seg_d;

  logic   same;
  logic   commit;
  logic   wrap;
  digit_t units;
  digit_t tens;
  seg_t   seg_units;
  seg_t   seg_tens;

  // Filter: track a candidate and commit it once it has held long enough
  always_comb begin
    same   = (value_pi == cand_q);
    commit = same && (cnt_q == CNT_MAX) &&
             (!done_q || (cand_q != val_q));
    cand_d = value_pi;
    cnt_d  = cnt_q;
    if (!same)
      cnt_d = '0;
    else if (cnt_q != CNT_MAX)
      cnt_d = cnt_q + 1'b1;
    val_d  = commit ? cand_q : val_q;
    upd_d  = commit;
    done_d = done_q | commit;
  end

  assign units = (val_q >= 4'd10) ? (val_q - 4'd10) : val_q;
  assign tens  = {3'b000, (val_q >= 4'd10)};

  seg7_digit_decode u_units (
    .digit_i (units),
    .seg_o   (seg_units)
  );

  seg7_digit_decode u_tens (
    .digit_i (tens),
    .seg_o   (seg_tens)
  );

  // Scan FSM: leave BLANK on first commit, then alternate digits
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    wrap    = (rcnt_q == REF_MAX);
    unique case (state_q)
      BLANK: begin
        if (commit) begin
          state_d = SHOW_UNITS;
          rcnt_d  = '0;
        end
      end
      SHOW_UNITS: begin
        rcnt_d = wrap ? '0 : rcnt_q + 1'b1;
        if (wrap)
          state_d = SHOW_TENS;
      end
      SHOW_TENS: begin
        rcnt_d = wrap ? '0 : rcnt_q + 1'b1;
        if (wrap)
          state_d = SHOW_UNITS;
      end
      default: begin
        state_d = BLANK;
        rcnt_d  = '0;
      end
    endcase
  end

  // Output drive follows the next slot; digits come from the held value
  always_comb begin
    an_d  = ANODE_OFF;
    seg_d = SEG_BLANK;
    case (state_d)
      SHOW_UNITS: begin
        an_d  = ANODE_UNITS;
        seg_d = seg_units;
      end
      SHOW_TENS: begin
        an_d  = ANODE_TENS;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        seg_d = (tens == 4'd0) ? SEG_BLANK : seg_tens;
`else
        seg_d = seg_tens;
`endif
      end
      default: begin
        an_d  = ANODE_OFF;
        seg_d = SEG_BLANK;
      end
    endcase
  end

  // Filter and commit registers
  always_ff @(posedge clk_pi) begin
    if (!rst_pi) begin
      cand_q <= '0;
      cnt_q  <= '0;
      val_q  <= '0;
      upd_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
      val_q  <= val_d;
      upd_q  <= upd_d;
      done_q <= done_d;
    end
  end

  // Scan state and registered display outputs
  always_ff @(posedge clk_pi) begin
    if (!rst_pi) begin
      state_q <= BLANK;
      rcnt_q  <= '0;
      an_q    <= ANODE_OFF;
      seg_q   <= SEG_BLANK;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign value_po  = val_q;
  assign update_po = upd_q;
  assign anodo_po  = an_q;
  assign catodo_po = seg_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl (REFRESH_DIV=4, STABLE_CYCLES=3).
// Honors SEG7_LEADING_ZERO_BLANK_EN for the zero tens pattern.
module tb_seg7_scan_ctrl;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  localparam logic [6:0] TENS0 = 7'h7F;
`else
  localparam logic [6:0] TENS0 = 7'h40;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  seg7_scan_ctrl_if bus();

  seg7_scan_ctrl #(
    .REFRESH_DIV   (4),
    .STABLE_CYCLES (3)
  ) dut (
    .clk_pi    (clk),
    .rst_pi    (rst),
    .value_pi  (bus.value),
    .value_po  (bus.committed),
    .update_po (bus.update),
    .anodo_po  (bus.anode),
    .catodo_po (bus.segs)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  int         e_at[$];
  string      e_nm[$];
  logic [1:0] e_an[$];
  logic [6:0] e_sg[$];
  logic [3:0] e_v[$];
  int         u_at[$];
  logic [3:0] u_v[$];

  task automatic exp(input int at, input string nm,
                     input logic [1:0] an, input logic [6:0] sg,
                     input logic [3:0] v);
    e_at.push_back(at);
    e_nm.push_back(nm);
    e_an.push_back(an);
    e_sg.push_back(sg);
    e_v.push_back(v);
  endtask

  task automatic exu(input int at, input logic [3:0] v);
    u_at.push_back(at);
    u_v.push_back(v);
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Monitor: compare display state and commit pulses on the falling edge
  always @(negedge clk) begin
    while (e_at.size() > 0 && e_at[0] <= cyc) begin
      int         at;
      string      nm;
      logic [1:0] an;
      logic [6:0] sg;
      logic [3:0] v;
      at = e_at.pop_front();
      nm = e_nm.pop_front();
      an = e_an.pop_front();
      sg = e_sg.pop_front();
      v  = e_v.pop_front();
      checks++;
      if (at != cyc || bus.anode !== an ||
          bus.segs !== sg || bus.committed !== v) begin
        failures++;
        $display("FAIL %s cyc=%0d got an=%b seg=%h val=%0d want cyc=%0d an=%b seg=%h val=%0d",
                 nm, cyc, bus.anode, bus.segs, bus.committed, at, an, sg, v);
      end
    end
    while (u_at.size() > 0 && u_at[0] < cyc) begin
      int at;
      logic [3:0] v;
      at = u_at.pop_front();
      v  = u_v.pop_front();
      checks++;
      failures++;
      $display("FAIL update_missing got none want cyc=%0d val=%0d", at, v);
    end
    if (bus.update === 1'b1) begin
      checks++;
      if (u_at.size() == 0) begin
        failures++;
        $display("FAIL update_spurious cyc=%0d got pulse val=%0d want no pulse",
                 cyc, bus.committed);
      end else begin
        int at;
        logic [3:0] v;
        at = u_at.pop_front();
        v  = u_v.pop_front();
        if (at != cyc || bus.committed !== v) begin
          failures++;
          $display("FAIL update cyc=%0d got val=%0d want cyc=%0d val=%0d",
                   cyc, bus.committed, at, v);
        end
      end
    end
  end

  // Stimulus: directed phases, each pushing its hand-computed results
  initial begin
    bus.value = 4'd0;
    rst = 1'b0;
    exp(2, "reset", 2'b11, 7'h7F, 4'd0);
    exp(3, "dark0", 2'b11, 7'h7F, 4'd0);
    exp(4, "dark1", 2'b11, 7'h7F, 4'd0);
    exu(5, 4'd0);
    exp(5, "first_units", 2'b10, 7'h40, 4'd0);
    exp(8, "units_end", 2'b10, 7'h40, 4'd0);
    exp(9, "tens_start", 2'b01, TENS0, 4'd0);
    exp(12, "tens_end", 2'b01, TENS0, 4'd0);
    exp(13, "units_again", 2'b10, 7'h40, 4'd0);
    wait_until(2);
    rst = 1'b1;

    wait_until(14);
    bus.value = 4'd13;
    exp(17, "v13_precommit", 2'b01, TENS0, 4'd0);
    exu(18, 4'd13);
    exp(18, "v13_commit", 2'b01, TENS0, 4'd13);
    exp(19, "v13_tens", 2'b01, 7'h79, 4'd13);
    exp(21, "v13_units", 2'b10, 7'h30, 4'd13);
    exp(25, "v13_tens2", 2'b01, 7'h79, 4'd13);

    wait_until(26);
    bus.value = 4'd5;
    exu(30, 4'd5);
    exp(31, "v5_units", 2'b10, 7'h12, 4'd5);
    wait_until(32);
    bus.value = 4'd9;
    exp(34, "glitch_tens", 2'b01, TENS0, 4'd5);
    exp(36, "glitch_tens2", 2'b01, TENS0, 4'd5);
    exp(38, "glitch_units", 2'b10, 7'h12, 4'd5);
    exp(40, "glitch_units2", 2'b10, 7'h12, 4'd5);
    wait_until(34);
    bus.value = 4'd5;

    wait_until(40);
    bus.value = 4'd7;
    exu(44, 4'd7);
    exp(46, "v7_units", 2'b10, 7'h78, 4'd7);
    exp(50, "v7_tens", 2'b01, TENS0, 4'd7);

    wait_until(50);
    bus.value = 4'd10;
    exu(54, 4'd10);
    exp(55, "v10_units", 2'b10, 7'h40, 4'd10);
    exp(58, "v10_tens", 2'b01, 7'h79, 4'd10);
    wait_until(57);
    bus.value = 4'd15;
    exp(60, "v15_pre", 2'b01, 7'h79, 4'd10);
    exu(61, 4'd15);
    exp(61, "v15_wrap", 2'b10, 7'h40, 4'd15);
    exp(62, "v15_units", 2'b10, 7'h12, 4'd15);
    exp(64, "v15_units2", 2'b10, 7'h12, 4'd15);
    exp(65, "v15_tens", 2'b01, 7'h79, 4'd15);

    wait_until(65);
    rst = 1'b0;
    exp(66, "mid_reset", 2'b11, 7'h7F, 4'd0);
    exp(67, "rec_dark0", 2'b11, 7'h7F, 4'd0);
    exp(68, "rec_dark1", 2'b11, 7'h7F, 4'd0);
    exu(69, 4'd0);
    exp(69, "rec_units", 2'b10, 7'h40, 4'd0);
    exp(72, "rec_units_end", 2'b10, 7'h40, 4'd0);
    exp(73, "rec_tens", 2'b01, TENS0, 4'd0);
    wait_until(66);
    rst = 1'b1;
    bus.value = 4'd0;

    wait_until(76);
    @(posedge clk);
    #1;
    while (e_at.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL leftover %s got unchecked want cyc=%0d", e_nm[0], e_at[0]);
      void'(e_at.pop_front());
      void'(e_nm.pop_front());
      void'(e_an.pop_front());
      void'(e_sg.pop_front());
      void'(e_v.pop_front());
    end
    while (u_at.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL update_leftover got none want cyc=%0d val=%0d", u_at[0], u_v[0]);
      void'(u_at.pop_front());
      void'(u_v.pop_front());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
